mac_tx_framer: RTL and testbench

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

---
 rtl/mac_tx_framer.sv | 174 +++++++++++++++++
 tb/tb_mac_tx_framer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, optional padding to a minimum
// length, IEEE 802.3 CRC-32 FCS, inter-frame gap and underrun handling.
module mac_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int PAD_EN    = 1,
  parameter int MIN_LEN   = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mac_tx_data,
  input  logic       mac_tx_valid,
  input  logic       mac_tx_sof,
  input  logic       mac_tx_eof,
  output logic       mac_tx_rdy,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_done,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DISCARD} state_t;

  localparam logic [10:0] MIN_LEN_B = 11'(MIN_LEN);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_BYTES - 1);

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [10:0] byte_cnt_reg, byte_cnt_next;
  logic [15:0] aux_cnt_reg, aux_cnt_next;
  logic [7:0]  txd_reg, txd_next;
  logic        en_reg, en_next;
  logic        er_reg, er_next;
  logic        done_reg, done_next;
  logic        und_reg, und_next;
  logic [10:0] byte_inc;
  logic [7:0]  fcs_bytes [4];

  // Reflected (LSB-first) CRC-32 update; register holds the bit-reversed CRC,
  // so the FCS is simply its complement sent low byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
      assign fcs_bytes[gi] = ~crc_reg[8*gi +: 8];
    end
  endgenerate

  assign byte_inc   = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg : byte_cnt_reg + 11'd1;
  assign mac_tx_rdy = rst_n && (state_reg == DATA || state_reg == DISCARD);

  // State names the action taken at the end of the current cycle; every
  // output is registered, so what is decided here appears one cycle later.
  always_comb begin
    state_next    = state_reg;
    crc_next      = crc_reg;
    byte_cnt_next = byte_cnt_reg;
    aux_cnt_next  = aux_cnt_reg;
    txd_next      = 8'h00;
    en_next       = 1'b0;
    er_next       = 1'b0;
    done_next     = 1'b0;
    und_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mac_tx_valid && mac_tx_sof) begin
          state_next    = PRE;
          txd_next      = 8'h55;
          en_next       = 1'b1;
          crc_next      = 32'hFFFF_FFFF;
          byte_cnt_next = 11'd0;
          aux_cnt_next  = 16'd1;
        end
      end
      PRE: begin
        txd_next     = 8'h55;
        en_next      = 1'b1;
        aux_cnt_next = aux_cnt_reg + 16'd1;
        if (aux_cnt_reg == 16'd6) state_next = SFD;
      end
      SFD: begin
        txd_next   = 8'hD5;
        en_next    = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        en_next = 1'b1;
        if (mac_tx_valid) begin
          txd_next      = mac_tx_data;
          crc_next      = crc_byte(crc_reg, mac_tx_data);
          byte_cnt_next = byte_inc;
          if (mac_tx_eof) begin
            aux_cnt_next = 16'd0;
            state_next   = (PAD_EN != 0 && byte_inc < MIN_LEN_B) ? PAD : FCS;
          end
        end else begin
          er_next    = 1'b1;
          und_next   = 1'b1;
          state_next = DISCARD;
        end
      end
      PAD: begin
        en_next       = 1'b1;
        crc_next      = crc_byte(crc_reg, 8'h00);
        byte_cnt_next = byte_inc;
        if (byte_inc >= MIN_LEN_B) begin
          aux_cnt_next = 16'd0;
          state_next   = FCS;
        end
      end
      FCS: begin
        en_next      = 1'b1;
        txd_next     = fcs_bytes[aux_cnt_reg[1:0]];
        aux_cnt_next = aux_cnt_reg + 16'd1;
        if (aux_cnt_reg == 16'd3) begin
          done_next    = 1'b1;
          aux_cnt_next = 16'd0;
          state_next   = IFG;
        end
      end
      IFG: begin
        aux_cnt_next = aux_cnt_reg + 16'd1;
        if (aux_cnt_reg >= IFG_LAST) begin
          aux_cnt_next = 16'd0;
          state_next   = IDLE;
        end
      end
      DISCARD: begin
        if (mac_tx_valid && mac_tx_eof) begin
          aux_cnt_next = 16'd0;
          state_next   = IFG;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      crc_reg      <= 32'hFFFF_FFFF;
      byte_cnt_reg <= 11'd0;
      aux_cnt_reg  <= 16'd0;
      txd_reg      <= 8'h00;
      en_reg       <= 1'b0;
      er_reg       <= 1'b0;
      done_reg     <= 1'b0;
      und_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      crc_reg      <= crc_next;
      byte_cnt_reg <= byte_cnt_next;
      aux_cnt_reg  <= aux_cnt_next;
      txd_reg      <= txd_next;
      en_reg       <= en_next;
      er_reg       <= er_next;
      done_reg     <= done_next;
      und_reg      <= und_next;
    end
  end

  assign gmii_txd    = txd_reg;
  assign gmii_tx_en  = en_reg;
  assign gmii_tx_er  = er_reg;
  assign tx_done     = done_reg;
  assign tx_underrun = und_reg;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Self-checking bench for mac_tx_framer: random payloads compared against a
// frame-level reference model (preamble, pad, forward CRC-32 FCS).
module tb_mac_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       valid = 1'b0, sof = 1'b0, eof = 1'b0;
  logic       sel = 1'b0;

  logic       rdy_p, en_p, er_p, done_p, und_p;
  logic [7:0] txd_p;
  logic       rdy_n, en_n, er_n, done_n, und_n;
  logic [7:0] txd_n;

  always #4 clk = ~clk;

  mac_tx_framer #(.IFG_BYTES(12), .PAD_EN(1), .MIN_LEN(60)) dut (
    .clk(clk), .rst_n(rst_n), .mac_tx_data(din), .mac_tx_valid(valid),
    .mac_tx_sof(sof), .mac_tx_eof(eof), .mac_tx_rdy(rdy_p), .gmii_txd(txd_p),
    .gmii_tx_en(en_p), .gmii_tx_er(er_p), .tx_done(done_p), .tx_underrun(und_p));

  mac_tx_framer #(.IFG_BYTES(12), .PAD_EN(0), .MIN_LEN(60)) dut_np (
    .clk(clk), .rst_n(rst_n), .mac_tx_data(din), .mac_tx_valid(valid),
    .mac_tx_sof(sof), .mac_tx_eof(eof), .mac_tx_rdy(rdy_n), .gmii_txd(txd_n),
    .gmii_tx_en(en_n), .gmii_tx_er(er_n), .tx_done(done_n), .tx_underrun(und_n));

  logic       m_rdy, m_en, m_er, m_done, m_und;
  logic [7:0] m_txd;
  assign m_rdy  = sel ? rdy_n  : rdy_p;
  assign m_en   = sel ? en_n   : en_p;
  assign m_er   = sel ? er_n   : er_p;
  assign m_done = sel ? done_n : done_p;
  assign m_und  = sel ? und_n  : und_p;
  assign m_txd  = sel ? txd_n  : txd_p;

  int checks = 0, failures = 0;

  // Monitor state
  logic [7:0] cap[$];
  int gaps[$];
  int done_cnt, done_idx, und_cnt, er_cnt, er_idx, gap_run, rdy_gap_viol;
  bit was_en, in_gap;

  always @(negedge clk) begin
    if (m_en) begin
      if (in_gap) begin gaps.push_back(gap_run); in_gap = 1'b0; end
      cap.push_back(m_txd);
      was_en = 1'b1;
    end else begin
      if (was_en) begin in_gap = 1'b1; gap_run = 0; was_en = 1'b0; end
      if (in_gap) begin gap_run++; if (m_rdy) rdy_gap_viol++; end
    end
    if (m_er) begin er_cnt++; er_idx = cap.size() - 1; end
    if (m_done) begin done_cnt++; done_idx = cap.size() - 1; end
    if (m_und) und_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1 ms, required to have finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    @(posedge clk);
    cap.delete(); gaps.delete();
    done_cnt = 0; done_idx = -1; und_cnt = 0; er_cnt = 0; er_idx = -1;
    gap_run = 0; rdy_gap_viol = 0; was_en = 1'b0; in_gap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Forward (MSB-register) CRC-32, feeding each byte LSB first.
  function automatic logic [31:0] crc_fwd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      r = r[31] ^ d[b] ? ({r[30:0], 1'b0} ^ 32'h04C1_1DB7) : {r[30:0], 1'b0};
    return r;
  endfunction

  task automatic build_expected(input logic [7:0] pl[$], input bit pad, output logic [7:0] exp[$]);
    logic [7:0] body[$];
    logic [31:0] c, f;
    logic [7:0] fb;
    exp.delete();
    body = pl;
    if (pad) while (body.size() < 60) body.push_back(8'h00);
    repeat (7) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    c = 32'hFFFF_FFFF;
    foreach (body[k]) begin exp.push_back(body[k]); c = crc_fwd(c, body[k]); end
    f = ~c;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) fb[j] = f[31 - (8*k + j)];
      exp.push_back(fb);
    end
  endtask

  function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int k = 0; k < n; k++) if (a[k] !== b[k]) return k;
    return -1;
  endfunction

  function automatic void rand_payload(input int len, output logic [7:0] pl[$]);
    pl.delete();
    for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Drives one frame honouring mac_tx_rdy; optional one-cycle valid drop
  // after drop_at accepted bytes, or a reset pulse while presenting byte rst_at.
  task automatic send_frame(input logic [7:0] pl[$], input int drop_at, input int rst_at, input bit hold);
    int i = 0, guard = 0;
    bit acc, dropped = 1'b0;
    while (i < pl.size()) begin
      @(negedge clk);
      if (drop_at >= 0 && i == drop_at && !dropped) begin
        valid = 1'b0; sof = 1'b0; eof = 1'b0; dropped = 1'b1;
        @(posedge clk);
        continue;
      end
      valid = 1'b1; din = pl[i]; sof = (i == 0); eof = (i == pl.size() - 1);
      if (rst_at >= 0 && i == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk);
        return;
      end
      acc = m_rdy;
      @(posedge clk);
      if (acc) i++;
      guard++;
      if (guard > 3000) begin
        checks++; failures++;
        $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, pl.size());
        break;
      end
    end
    if (!hold) begin
      @(negedge clk);
      valid = 1'b0; sof = 1'b0; eof = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin @(posedge clk); n++; end
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL done_timeout: tx_done pulses %0d, required %0d", done_cnt, target);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b1; sof = 1'b1; din = 8'h11;
    @(posedge clk);
    @(negedge clk);
    checks++; if (en_p !== 1'b0)   begin failures++; $display("FAIL reset_en: got %b, required 0", en_p); end
    checks++; if (txd_p !== 8'h00) begin failures++; $display("FAIL reset_txd: got %02h, required 00", txd_p); end
    checks++; if (er_p !== 1'b0)   begin failures++; $display("FAIL reset_er: got %b, required 0", er_p); end
    checks++; if (done_p !== 1'b0 || und_p !== 1'b0) begin failures++; $display("FAIL reset_pulses: done=%b und=%b, required 0 0", done_p, und_p); end
    checks++; if (rdy_p !== 1'b0)  begin failures++; $display("FAIL reset_rdy: got %b, required 0", rdy_p); end
    valid = 1'b0; sof = 1'b0;
    rst_n = 1'b1;
    clear_mon();
    @(negedge clk);
    valid = 1'b1; sof = 1'b0; eof = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    valid = 1'b0; eof = 1'b0;
    checks++; if (cap.size() != 0 || m_rdy !== 1'b0) begin failures++; $display("FAIL idle_no_sof: bytes=%0d rdy=%b, required 0 0", cap.size(), m_rdy); end
    $display("test_reset done");
  endtask

  task automatic test_crc_vector();
    logic [7:0] pl[$], exp[$];
    logic [7:0] fcs[4];
    int d;
    sel = 1'b1;
    do_reset();
    clear_mon();
    for (int k = 0; k < 9; k++) pl.push_back(8'h31 + 8'(k));
    fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    repeat (7) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    foreach (pl[k]) exp.push_back(pl[k]);
    foreach (fcs[k]) exp.push_back(fcs[k]);
    send_frame(pl, -1, -1, 1'b0);
    wait_done(1);
    d = first_diff(cap, exp);
    checks++; if (cap.size() != 21) begin failures++; $display("FAIL crc_vec_len: tx_en cycles %0d, required 21", cap.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL crc_vec_bytes: byte %0d got %02h, required %02h", d, cap[d], exp[d]); end
    checks++; if (done_idx != 20 || done_cnt != 1) begin failures++; $display("FAIL crc_vec_done: pulse at byte %0d count %0d, required 20 1", done_idx, done_cnt); end
    sel = 1'b0;
    do_reset();
    $display("test_crc_vector done");
  endtask

  task automatic test_arp_pad();
    logic [7:0] arp[42] = '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF, 8'hE0,8'h91,8'hF5,8'hB4,8'h06,8'hB0,
                            8'h08,8'h06, 8'h00,8'h01,8'h08,8'h00,8'h06,8'h04,8'h00,8'h01,
                            8'hE0,8'h91,8'hF5,8'hB4,8'h06,8'hB0, 8'hC0,8'hA8,8'h01,8'h64,
                            8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 8'hC0,8'hA8,8'h01,8'h01};
    logic [7:0] pl[$], exp[$];
    logic [31:0] res;
    int nz, d;
    sel = 1'b0;
    clear_mon();
    foreach (arp[k]) pl.push_back(arp[k]);
    build_expected(pl, 1'b1, exp);
    send_frame(pl, -1, -1, 1'b0);
    wait_done(1);
    nz = 0;
    for (int k = 50; k < 68 && k < cap.size(); k++) if (cap[k] !== 8'h00) nz++;
    res = 32'hFFFF_FFFF;
    for (int k = 8; k < cap.size(); k++) res = crc_fwd(res, cap[k]);
    d = first_diff(cap, exp);
    checks++; if (cap.size() != 72) begin failures++; $display("FAIL arp_len: bytes after SFD %0d, required 64", cap.size() - 8); end
    checks++; if (nz != 0) begin failures++; $display("FAIL arp_pad: %0d nonzero pad bytes, required 0", nz); end
    checks++; if (res !== 32'hC704_DD7B) begin failures++; $display("FAIL arp_residue: got %08h, required C704DD7B", res); end
    checks++; if (d >= 0) begin failures++; $display("FAIL arp_bytes: byte %0d got %02h, required %02h", d, cap[d], exp[d]); end
    $display("test_arp_pad done");
  endtask

  task automatic test_one_byte();
    logic [7:0] pl[$], exp[$];
    int d;
    clear_mon();
    pl.push_back(8'hAB);
    build_expected(pl, 1'b1, exp);
    send_frame(pl, -1, -1, 1'b0);
    wait_done(1);
    d = first_diff(cap, exp);
    checks++; if (cap.size() != exp.size()) begin failures++; $display("FAIL one_byte_len: got %0d, required %0d", cap.size(), exp.size()); end
    checks++; if (d >= 0) begin failures++; $display("FAIL one_byte_bytes: byte %0d got %02h, required %02h", d, cap[d], exp[d]); end
    checks++; if (done_idx != cap.size() - 1) begin failures++; $display("FAIL one_byte_done: pulse at %0d, required %0d", done_idx, cap.size() - 1); end
    $display("test_one_byte done");
  endtask

  task automatic test_random_frames();
    int lens[6];
    logic [7:0] pl[$], exp[$];
    int d;
    lens = '{59, 60, 61, 0, 0, 0};
    for (int f = 3; f < 6; f++) lens[f] = $urandom_range(2, 90);
    for (int f = 0; f < 6; f++) begin
      clear_mon();
      rand_payload(lens[f], pl);
      build_expected(pl, 1'b1, exp);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send_frame(pl, -1, -1, 1'b0);
      wait_done(1);
      d = first_diff(cap, exp);
      checks++; if (cap.size() != exp.size()) begin failures++; $display("FAIL rand%0d_len: got %0d, required %0d", f, cap.size(), exp.size()); end
      checks++; if (d >= 0) begin failures++; $display("FAIL rand%0d_bytes: byte %0d got %02h, required %02h", f, d, cap[d], exp[d]); end
      checks++; if (done_idx != cap.size() - 1 || er_cnt != 0) begin failures++; $display("FAIL rand%0d_flags: done at %0d er=%0d, required %0d 0", f, done_idx, er_cnt, cap.size() - 1); end
      $display("frame %0d len=%0d tx_bytes=%0d", f, lens[f], cap.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1[$], p2[$], e1[$], e2[$], exp[$];
    int d;
    clear_mon();
    rand_payload($urandom_range(60, 70), p1);
    rand_payload($urandom_range(1, 30), p2);
    build_expected(p1, 1'b1, e1);
    build_expected(p2, 1'b1, e2);
    exp = {e1, e2};
    send_frame(p1, -1, -1, 1'b1);
    send_frame(p2, -1, -1, 1'b0);
    wait_done(2);
    d = first_diff(cap, exp);
    checks++; if (gaps.size() < 1 || gaps[0] != 12) begin failures++; $display("FAIL b2b_gap: gap %0d cycles, required 12", (gaps.size() > 0) ? gaps[0] : -1); end
    checks++; if (rdy_gap_viol != 0) begin failures++; $display("FAIL b2b_rdy: rdy high %0d gap cycles, required 0", rdy_gap_viol); end
    checks++; if (cap.size() != exp.size() || d >= 0) begin failures++; $display("FAIL b2b_bytes: len %0d first diff %0d, required len %0d no diff", cap.size(), d, exp.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_underrun();
    logic [7:0] pl[$], exp[$];
    int d;
    logic [7:0] pre[$];
    clear_mon();
    rand_payload(40, pl);
    build_expected(pl, 1'b1, exp);
    send_frame(pl, 20, -1, 1'b0);
    repeat (30) @(posedge clk);
    pre = exp[0:27];
    cap = cap;
    d = -1;
    for (int k = 0; k < 28 && k < cap.size(); k++) if (d < 0 && cap[k] !== pre[k]) d = k;
    checks++; if (und_cnt != 1) begin failures++; $display("FAIL und_pulse: got %0d pulses, required 1", und_cnt); end
    checks++; if (er_cnt != 1 || er_idx != 28) begin failures++; $display("FAIL und_er: count %0d at byte %0d, required 1 at 28", er_cnt, er_idx); end
    checks++; if (cap.size() != 29) begin failures++; $display("FAIL und_len: tx_en cycles %0d, required 29", cap.size()); end
    checks++; if (cap.size() > 28 && cap[28] !== 8'h00) begin failures++; $display("FAIL und_txd: got %02h, required 00", cap[28]); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL und_done: got %0d pulses, required 0", done_cnt); end
    checks++; if (d >= 0) begin failures++; $display("FAIL und_prefix: byte %0d got %02h, required %02h", d, cap[d], pre[d]); end
    $display("test_underrun done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] p1[$], p2[$], exp[$];
    int d;
    clear_mon();
    rand_payload(30, p1);
    send_frame(p1, -1, 10, 1'b0);
    @(negedge clk);
    checks++; if (m_en !== 1'b0) begin failures++; $display("FAIL midrst_en: got %b, required 0", m_en); end
    rst_n = 1'b1; valid = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (20) @(posedge clk);
    checks++; if (done_cnt != 0 || cap.size() != 18) begin failures++; $display("FAIL midrst_abort: done=%0d bytes=%0d, required 0 18", done_cnt, cap.size()); end
    clear_mon();
    rand_payload($urandom_range(20, 70), p2);
    build_expected(p2, 1'b1, exp);
    send_frame(p2, -1, -1, 1'b0);
    wait_done(1);
    d = first_diff(cap, exp);
    checks++; if (cap.size() != exp.size() || d >= 0) begin failures++; $display("FAIL midrst_next: len %0d first diff %0d, required len %0d no diff", cap.size(), d, exp.size()); end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_arp_pad();
    test_one_byte();
    test_random_frames();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
